// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes
// and the 3-sample majority helper used by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Bit timer and 3-sample majority vote for the UART receiver.
// Ports: clk, reset, rs (synchronised rx), clear (hold timer at 0),
//        bit_val (voted bit), decide (vote valid), bit_end (last tick of bit).
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 39
) (
    input  logic clk,
    input  logic reset,
    input  logic rs,
    input  logic clear,
    output logic bit_val,
    output logic decide,
    output logic bit_end
);

    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;

    localparam logic [TW-1:0] T_S0   = TW'(MID - 1);
    localparam logic [TW-1:0] T_S1   = TW'(MID);
    localparam logic [TW-1:0] T_DEC  = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] tcnt;
    logic          s0;
    logic          s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            s0   <= 1'b1;
            s1   <= 1'b1;
        end else begin
            if (clear || tcnt == T_LAST)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
            if (tcnt == T_S0)
                s0 <= rs;
            if (tcnt == T_S1)
                s1 <= rs;
        end
    end

    // Third sample is the live rs value in the decide cycle.
    assign bit_val = maj3(s0, s1, rs);
    assign decide  = (tcnt == T_DEC);
    assign bit_end = (tcnt == T_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DBIT data bits, optional parity, 1-2 stop bits.
// Ports: clk, reset, rx -> rx_done_tick, dout, parity_err, frame_err, busy.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 39,
    parameter int DBIT         = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            busy
);

    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 1023) begin : g_bad_cpb
        $error("CLKS_PER_BIT out of range");
    end
    if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
        $error("DBIT out of range");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
        $error("PARITY_MODE illegal");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS illegal");
    end

    localparam logic [3:0] DLAST  = 4'(DBIT - 1);
    localparam logic [3:0] SLAST  = 4'(STOP_BITS - 1);
    localparam bit         PAR_EN = (PARITY_MODE != PARITY_NONE);
    localparam bit         PAR_OD = (PARITY_MODE == PARITY_ODD);

    logic            sync1;
    logic            rs;
    state_t          state;
    state_t          state_next;
    logic [3:0]      bcnt;
    logic [DBIT-1:0] data;
    logic            par_flag;
    logic            frm_flag;
    logic            clear;
    logic            bit_val;
    logic            decide;
    logic            bit_end;
    logic            done;
    logic            arm;
    logic            shift_en;
    logic            par_en;
    logic            stop_en;
    logic            par_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rs    <= 1'b1;
        end else begin
            sync1 <= rx;
            rs    <= sync1;
        end
    end

    // Timer is held at 0 in IDLE and zeroed on the way back to IDLE,
    // so START always begins with tcnt = 0.
    assign clear = (state == S_IDLE) || (state_next == S_IDLE);

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk    (clk),
        .reset  (reset),
        .rs     (rs),
        .clear  (clear),
        .bit_val(bit_val),
        .decide (decide),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:
                if (!rs)
                    state_next = S_START;
            S_START:
                if (decide && bit_val)
                    state_next = S_IDLE;
                else if (bit_end)
                    state_next = S_DATA;
            S_DATA:
                if (bit_end && bcnt == DLAST)
                    state_next = PAR_EN ? S_PARITY : S_STOP;
            S_PARITY:
                if (bit_end)
                    state_next = S_STOP;
            S_STOP:
                // Finish mid last stop bit to catch a back-to-back start.
                if (decide && bcnt == SLAST)
                    state_next = S_IDLE;
            default:
                state_next = S_IDLE;
        endcase
    end

    always_comb begin
        arm      = (state == S_IDLE) && !rs;
        shift_en = (state == S_DATA) && decide;
        par_en   = (state == S_PARITY) && decide;
        stop_en  = (state == S_STOP) && decide;
        done     = stop_en && (bcnt == SLAST);
        busy     = (state != S_IDLE);
    end

    assign par_x = (^data) ^ bit_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt         <= '0;
            data         <= '0;
            par_flag     <= 1'b0;
            frm_flag     <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            rx_done_tick <= done;
            if (state_next != state)
                bcnt <= '0;
            else if (bit_end && (state == S_DATA || state == S_STOP))
                bcnt <= bcnt + 1'b1;
            if (arm) begin
                par_flag <= 1'b0;
                frm_flag <= 1'b0;
            end
            if (shift_en)
                data <= {bit_val, data[DBIT-1:1]};
            if (par_en)
                par_flag <= PAR_OD ? ~par_x : par_x;
            if (stop_en && !bit_val)
                frm_flag <= 1'b1;
            if (done) begin
                dout       <= data;
                parity_err <= par_flag;
                frame_err  <= frm_flag | ~bit_val;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: four receiver configurations
// (8N1, 8E1, 8O1, 7N2 at 16 clocks/bit) fed from a scoreboard queue.
module tb_uart_rx_cfg;

    localparam int CPB = 16;
    localparam int M   = (CPB - 1) / 2;

    typedef struct packed {
        int         u;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        int         lat;
        int         t0;
    } exp_t;

    typedef struct packed {
        int         u;
        logic [8:0] d;
        logic       p;
        logic [1:0] st;
        logic [8:0] xd;
        logic       xpe;
        logic       xfe;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] rxv;
    wire  [3:0] tick;
    wire  [3:0] pe;
    wire  [3:0] fe;
    wire  [3:0] bsy;
    wire  [7:0] dout_n1;
    wire  [7:0] dout_e1;
    wire  [7:0] dout_o1;
    wire  [6:0] dout_72;
    wire  [8:0] da [4];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   brk_ticks = 0;
    bit   brk   = 0;
    bit   drain = 0;
    exp_t q[$];
    vec_t tv[9];

    assign da[0] = {1'b0, dout_n1};
    assign da[1] = {1'b0, dout_e1};
    assign da[2] = {1'b0, dout_o1};
    assign da[3] = {2'b0, dout_72};

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DBIT(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .reset(reset), .rx(rxv[0]), .rx_done_tick(tick[0]),
        .dout(dout_n1), .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DBIT(8), .PARITY_MODE(1), .STOP_BITS(1)) u_e1 (
        .clk(clk), .reset(reset), .rx(rxv[1]), .rx_done_tick(tick[1]),
        .dout(dout_e1), .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DBIT(8), .PARITY_MODE(2), .STOP_BITS(1)) u_o1 (
        .clk(clk), .reset(reset), .rx(rxv[2]), .rx_done_tick(tick[2]),
        .dout(dout_o1), .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DBIT(7), .PARITY_MODE(0), .STOP_BITS(2)) u_72 (
        .clk(clk), .reset(reset), .rx(rxv[3]), .rx_done_tick(tick[3]),
        .dout(dout_72), .parity_err(pe[3]), .frame_err(fe[3]), .busy(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int nbits(input int u);
        return (u == 3) ? 7 : 8;
    endfunction

    function automatic int npar(input int u);
        return (u == 1 || u == 2) ? 1 : 0;
    endfunction

    function automatic int nstop(input int u);
        return (u == 3) ? 2 : 1;
    endfunction

    // Pin-to-tick edges: frame formula + 2 synchroniser edges + 1 for the
    // first edge after the pin changes mid-cycle.
    function automatic int lat_of(input int u);
        return (1 + nbits(u) + npar(u) + nstop(u) - 1) * CPB + M + 2 + 3;
    endfunction

    task automatic bit_out(input int u, input logic b, input bit gl);
        rxv[u] = b;
        if (gl) begin
            repeat (10) @(negedge clk);
            rxv[u] = ~b;
            @(negedge clk);
            rxv[u] = b;
            repeat (CPB - 11) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send(input int u, input logic [8:0] d, input logic p,
                        input logic [1:0] st, input int gl);
        bit_out(u, 1'b0, 1'b0);
        for (int i = 0; i < nbits(u); i++)
            bit_out(u, d[i], gl == i);
        if (npar(u) != 0)
            bit_out(u, p, 1'b0);
        for (int i = 0; i < nstop(u); i++)
            bit_out(u, st[i], 1'b0);
        rxv[u] = 1'b1;
    endtask

    task automatic expect_char(input int u, input logic [8:0] d,
                               input logic xpe, input logic xfe, input int lat);
        exp_t e;
        e.u   = u;
        e.d   = d;
        e.pe  = xpe;
        e.fe  = xfe;
        e.lat = lat;
        e.t0  = cyc;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q_empty", q.size(), 0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int u = 0; u < 4; u++) begin
            if (tick[u] && !drain) begin
                if (brk && u == 0) begin
                    brk_ticks++;
                    chk("brk_dout", int'(da[0]), 0);
                    chk("brk_fe", int'(fe[0]), 1);
                    chk("brk_pe", int'(pe[0]), 0);
                end else if (q.size() == 0) begin
                    chk("unexpected_tick_unit", u, -1);
                end else begin
                    e = q.pop_front();
                    chk("tick_unit", u, e.u);
                    chk("dout", int'(da[u]), int'(e.d));
                    chk("parity_err", int'(pe[u]), int'(e.pe));
                    chk("frame_err", int'(fe[u]), int'(e.fe));
                    if (e.lat != 0)
                        chk("latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    initial begin
        tv[0] = '{u: 1, d: 9'h07, p: 1'b0, st: 2'b11, xd: 9'h07, xpe: 1'b1, xfe: 1'b0};
        tv[1] = '{u: 1, d: 9'h07, p: 1'b1, st: 2'b11, xd: 9'h07, xpe: 1'b0, xfe: 1'b0};
        tv[2] = '{u: 2, d: 9'h07, p: 1'b0, st: 2'b11, xd: 9'h07, xpe: 1'b0, xfe: 1'b0};
        tv[3] = '{u: 2, d: 9'h07, p: 1'b1, st: 2'b11, xd: 9'h07, xpe: 1'b1, xfe: 1'b0};
        tv[4] = '{u: 1, d: 9'hC3, p: 1'b0, st: 2'b11, xd: 9'hC3, xpe: 1'b0, xfe: 1'b0};
        tv[5] = '{u: 0, d: 9'h00, p: 1'b0, st: 2'b00, xd: 9'h00, xpe: 1'b0, xfe: 1'b1};
        tv[6] = '{u: 3, d: 9'h55, p: 1'b0, st: 2'b11, xd: 9'h55, xpe: 1'b0, xfe: 1'b0};
        tv[7] = '{u: 3, d: 9'h2A, p: 1'b0, st: 2'b01, xd: 9'h2A, xpe: 1'b0, xfe: 1'b1};
        tv[8] = '{u: 0, d: 9'hA5, p: 1'b0, st: 2'b11, xd: 9'hA5, xpe: 1'b0, xfe: 1'b0};

        reset = 1'b1;
        rxv   = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(bsy), 0);
        chk("rst_pe", int'(pe), 0);
        chk("rst_fe", int'(fe), 0);
        chk("rst_dout_n1", int'(dout_n1), 0);
        chk("rst_dout_72", int'(dout_72), 0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Table: single characters on each configuration.
        for (int i = 0; i < 9; i++) begin
            expect_char(tv[i].u, tv[i].xd, tv[i].xpe, tv[i].xfe, lat_of(tv[i].u));
            send(tv[i].u, tv[i].d, tv[i].p, tv[i].st, -1);
            wait_drain(20 * CPB);
        end

        // Short low pulse in IDLE: false start, outputs untouched.
        rxv[0] = 1'b0;
        repeat (3) @(negedge clk);
        rxv[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_hi", int'(bsy[0]), 1);
        repeat (10) @(negedge clk);
        chk("glitch_busy_lo", int'(bsy[0]), 0);
        chk("glitch_dout", int'(dout_n1), 'hA5);
        chk("glitch_fe", int'(fe[0]), 0);
        repeat (2 * CPB) @(negedge clk);

        // One-cycle glitch in the middle of data bit 3.
        expect_char(0, 9'hFF, 1'b0, 1'b0, lat_of(0));
        send(0, 9'hFF, 1'b0, 2'b11, 3);
        wait_drain(20 * CPB);

        // 7N2 back-to-back, first char with a low second stop bit.
        expect_char(3, 9'h55, 1'b0, 1'b1, lat_of(3));
        send(3, 9'h55, 1'b0, 2'b01, -1);
        expect_char(3, 9'h2A, 1'b0, 1'b0, 0);
        send(3, 9'h2A, 1'b0, 2'b11, -1);
        wait_drain(20 * CPB);

        // Break: 30 bit periods low on the 8N1 unit.
        brk    = 1'b1;
        rxv[0] = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        rxv[0] = 1'b1;
        brk    = 1'b0;
        drain  = 1'b1;
        repeat (14 * CPB) @(negedge clk);
        drain  = 1'b0;
        chk("brk_tick_count", brk_ticks, 3);
        chk("brk_busy_after", int'(bsy[0]), 0);
        expect_char(0, 9'h3C, 1'b0, 1'b0, lat_of(0));
        send(0, 9'h3C, 1'b0, 2'b11, -1);
        wait_drain(20 * CPB);

        // Reset in the middle of DATA of 0xFF.
        rxv[0] = 1'b0;
        repeat (CPB) @(negedge clk);
        rxv[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("midrst_busy_pre", int'(bsy[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", int'(bsy[0]), 0);
        chk("midrst_dout", int'(dout_n1), 0);
        chk("midrst_tick", int'(tick[0]), 0);
        chk("midrst_fe", int'(fe[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        expect_char(0, 9'h81, 1'b0, 1'b0, lat_of(0));
        send(0, 9'h81, 1'b0, 2'b11, -1);
        wait_drain(20 * CPB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the UART component. Configurable data width, parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote, and parity and framing errors are reported per character. Sits between the board rx pin and the UART RX FIFO / command decoder; uses the same done-tick handshake.

Parameters:
CLKS_PER_BIT, 39, clk cycles per bit period; legal range 8..1023.
DBIT, 8, data bits per character; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; 3 is illegal (elaboration error).
STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx  in  1  serial input, idle high, asynchronous to clk
rx_done_tick  out  1  one-cycle pulse: character complete
dout  out  DBIT  received character, LSB = first data bit
parity_err  out  1  parity mismatch for the character in dout
frame_err  out  1  a stop bit sampled low for the character in dout
busy  out  1  high while not in IDLE

Behaviour:
- Reset (async, active-high):
  - both synchroniser flops = 1; state = IDLE; counters = 0.
  - dout = 0; rx_done_tick = parity_err = frame_err = busy = 0.
- rx passes through a 2-flop synchroniser; all logic uses the second flop (rs).
- Bit timer tcnt, width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, then wraps to 0 and the bit counter advances.
- Majority sampling: M = (CLKS_PER_BIT-1)/2 (integer division).
  - rs captured at tcnt = M-1, M, M+1.
  - Bit value = majority of the 3 samples, decided at tcnt = M+1.
- States:
  - IDLE: tcnt = 0, bit index = 0. rs==0 -> START, with tcnt = 0 on the next cycle.
  - START: at the decision point, vote 1 -> IDLE (false start, no tick, no flag change). Vote 0 -> continue to tcnt end -> DATA.
  - DATA: DBIT bits, LSB first, into a shift/index register. After bit DBIT-1 ends -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: voted bit compared with XOR of the data bits. Even: error if XOR(data) ^ p = 1. Odd: error if XOR(data) ^ p = 0. Result held internally.
  - STOP: STOP_BITS stop bits, each voted. Any vote 0 sets the internal frame flag.
- Completion: at the decision point of the last stop bit, in one cycle:
  - dout, parity_err and frame_err are loaded;
  - rx_done_tick = 1 for exactly 1 cycle;
  - state -> IDLE.
  - The remainder of the stop bit is not waited out, so a back-to-back start bit is caught.
- dout, parity_err and frame_err hold their values until the next completion. They are not updated on a false start.
- parity_err is always 0 when PARITY_MODE = 0.
- Latency: the tick occurs (1 + DBIT + P + STOP_BITS - 1)*CLKS_PER_BIT + M + 2 cycles after the first cycle rs==0 is seen in IDLE (P = 1 if parity enabled). Synchroniser delay adds 2 cycles from the rx pin.
- Break condition (rx held low): completes with frame_err = 1 and dout = 0. The receiver then re-enters START on the next cycle while rx stays low and repeats; no lockup.
- reset asserted mid-character: immediate return to reset values; the partial character is discarded.
- busy = (state != IDLE).

Decomposition:
- uart_pkg: state encoding constants (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP) and PARITY_NONE/EVEN/ODD constants, shared with the matching transmitter.
- One sub-module, uart_bit_sampler: owns tcnt, the 3-sample capture and the majority vote. Outputs bit_val and decide and bit_end strobes; takes a clear input from the FSM.
- Synchroniser and FSM stay in uart_rx_cfg.

Test Plan:
1. CLKS_PER_BIT=16, 8N1, send 0xA5 with stop=1 -> one rx_done_tick, dout=0xA5, parity_err=0, frame_err=0; tick at the latency formula value ±0.
2. 8E1, send 0x07 with parity bit 0 (wrong, correct is 1) -> dout=0x07, parity_err=1. Then 0x07 with parity 1 -> parity_err=0. Repeat in 8O1 with inverted expectations.
3. Glitch: rx low for 3 cycles in IDLE at CLKS_PER_BIT=16 -> no tick, outputs unchanged, busy returns to 0 by cycle M+2. Single-cycle low glitch at mid data bit -> bit still decoded correctly.
4. 7N2, send 0x55 then 0x2A back-to-back with no idle gap; second stop bit of the first char forced low -> first char dout=0x55, frame_err=1; second dout=0x2A, frame_err=0.
5. rx held low for 30 bit periods -> repeated ticks with dout=0 and frame_err=1, no hang. Release -> next valid 0x3C is received cleanly.
6. Assert reset mid DATA of 0xFF -> outputs go to 0 asynchronously (checked before the next clk edge). After release, 0x81 is received correctly.
